cl_capture_ctrl: RTL and testbench
==================================

Name: cl_capture_ctrl

Overview:
Frame-acceptance sequencer for the Camera Link base receive path, clocked in the deserialiser pixel domain (rxclk_div). It decides which camera frames enter the pixel FIFO, based on lock, DMA idle/done, camera select and a frame-decimation setting. It generates the FIFO reset and the per-cycle write enable, checks line and frame geometry against configuration, and reports sticky errors. Upstream is the deserialiser (FVAL/LVAL/DVAL); downstream are the async pixel FIFO and the sys_clk line reader.

Parameters:
CNT_W, 16, width of pixel/line/frame counters and geometry config
SKIP_W, 4, width of frame-decimation count

Ports:
rxclk_div  in  1  pixel-domain clock
sys_rst  in  1  reset
locked  in  1  deserialiser locked and phase-aligned (already in rxclk_div domain)
cfg_enable  in  1  capture enable (quasi-static)
fval  in  1  frame valid
lval  in  1  line valid
dval  in  1  data valid
dma_idle  in  1  DMA idle, synchronised to rxclk_div
dma_done  in  1  one-cycle pulse, DMA busy-to-idle, synchronised
camera_sel  in  1  this camera selected, synchronised
fifo_full  in  1  pixel FIFO full (write side)
cfg_line_width  in  CNT_W  expected pixels per line (even)
cfg_frame_height  in  CNT_W  expected lines per frame
cfg_skip  in  SKIP_W  accept 1 of every cfg_skip+1 eligible frames
err_clr  in  1  one-cycle pulse, clears sticky errors
fifo_rst  out  1  pixel FIFO reset
pixel_wr_en  out  1  FIFO write enable, aligned to registered pixel data
frame_active  out  1  high in CAPTURE and DRAIN
frame_start  out  1  one-cycle pulse on CAPTURE entry
frame_end  out  1  one-cycle pulse on CAPTURE exit
frame_cnt  out  CNT_W  accepted frames, wraps
drop_cnt  out  CNT_W  frames dropped for busy/not-selected, saturates
err_line_len  out  1  sticky
err_height  out  1  sticky
err_overflow  out  1  sticky
state_o  out  3  current state encoding
meas_line_width  out  CNT_W  optional stats
meas_frame_height  out  CNT_W  optional stats

Behaviour:
- Reset: sys_rst, asynchronous, active-high; clock rxclk_div. On reset: state IDLE, fifo_rst=1, all other outputs 0, skip counter 0.
- All outputs are registered. pixel_wr_en = fval&lval&dval&~fifo_full in CAPTURE, with 1-cycle latency (matches one pipeline stage of pixel data).
- States: IDLE=0, WAIT_FEND=1, ARMED=2, CAPTURE=3, SKIP=4, DRAIN=5.
- Any state: if locked=0 or cfg_enable=0, go to IDLE next cycle. This aborts mid-frame without frame_end and without error update.
- IDLE: fifo_rst=1. Go to WAIT_FEND when locked&cfg_enable.
- WAIT_FEND: fifo_rst=1. Go to ARMED when fval=0. A capture never starts mid-frame.
- ARMED: fifo_rst=0. On fval rising edge:
  - if dma_idle&camera_sel and skip_cnt=0: go to CAPTURE, reload skip_cnt=cfg_skip, latch cfg_line_width/cfg_frame_height.
  - else if dma_idle&camera_sel: decrement skip_cnt, go to SKIP.
  - else: drop_cnt+1, go to SKIP.
- SKIP: go to ARMED when fval=0.
- CAPTURE:
  - pix_cnt+2 per write cycle.
  - On lval falling edge: err_line_len set if pix_cnt≠latched width; line_cnt+1; pix_cnt cleared.
  - A write attempt while fifo_full sets err_overflow; the write is suppressed.
  - On fval falling: err_height set if line_cnt≠latched height; frame_cnt+1; frame_end; go to DRAIN.
  - lval falling and fval falling in the same cycle: the line check is done first, then the height check includes that line.
- DRAIN: fifo_rst=0. Go to WAIT_FEND on dma_done. fval rising while in DRAIN counts as a drop.
- pix_cnt, line_cnt and drop_cnt saturate at all-ones; frame_cnt wraps.
- err_clr and an error set in the same cycle: the error set wins.

Optional Feature:
CL_FRAME_STATS_EN:
- Defined: meas_line_width captures pix_cnt at every lval falling edge in CAPTURE or SKIP; meas_frame_height captures the line count at every fval falling edge. SKIP frames are counted with a separate line counter.
- Undefined: both outputs are tied to 0 and no counter logic is present in SKIP.

Decomposition:
- Package cl_ctrl_pkg: state encoding constants, CNT_W/SKIP_W defaults, state_o widths.
- Sub-module cl_line_counter: lval/fval edge detection, pix_cnt/line_cnt with saturation, line-length compare, error pulses to the parent.

Test Plan:
1. Reset, then locked=1, cfg_enable=1, fval low; frame of 4 lines × 8 pixels (4 dval cycles), width=8, height=4 -> fifo_rst deasserts, 16 pixel_wr_en cycles, frame_cnt=1, no errors.
2. Enable while fval=1 mid-frame -> stays WAIT_FEND until fval falls; no writes until the next full frame.
3. cfg_skip=2, 6 frames, dma_done after each capture -> frames 1 and 4 captured, frame_cnt=2.
4. dma_idle=0 at a frame start -> SKIP, drop_cnt=1; a frame arriving during DRAIN -> drop_cnt=2.
5. One line with 6 pixels (width=8); frame with 3 lines (height=4) -> err_line_len=1 and err_height=1; err_clr clears both; err_clr coincident with a new error -> error stays 1.
6. locked drops mid-CAPTURE -> IDLE next cycle, fifo_rst=1, pixel_wr_en=0, no frame_end; fifo_full during a write -> err_overflow=1, write suppressed.

Source files
------------

// File: rtl/cl_ctrl_pkg.sv
// cl_ctrl_pkg: state encoding and default widths shared by the capture controller files.
package cl_ctrl_pkg;
  localparam int CNT_W_DEF = 16;
  localparam int SKIP_W_DEF = 4;
  localparam int ST_W = 3;
  typedef enum logic [ST_W-1:0] {
    IDLE      = 3'd0,
    WAIT_FEND = 3'd1,
    ARMED     = 3'd2,
    CAPTURE   = 3'd3,
    SKIP      = 3'd4,
    DRAIN     = 3'd5
  } cl_state_e;
endpackage

// File: rtl/cl_capture_ctrl_if.sv
// cl_capture_ctrl_if: camera timing strobes plus the pixel FIFO write-side handshake.
interface cl_capture_ctrl_if;
  logic fval;
  logic lval;
  logic dval;
  logic fifo_full;
  logic fifo_rst;
  logic pixel_wr_en;
  modport master (output fval, lval, dval, fifo_full, input fifo_rst, pixel_wr_en);
  modport slave (input fval, lval, dval, fifo_full, output fifo_rst, pixel_wr_en);
endinterface

// File: rtl/cl_line_counter.sv
// cl_line_counter: fval/lval edge detection, saturating pixel/line counts and line-length check.
// Width statistics exist only when CL_FRAME_STATS_EN is defined.
module cl_line_counter
  import cl_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             rxclk_div,
  input  logic             sys_rst,
  input  logic             i_fval,
  input  logic             i_lval,
  input  logic             i_dval,
  input  logic             i_pix_en,
  input  logic             i_line_en,
  input  logic [CNT_W-1:0] i_width,
  output logic             o_fval_rise,
  output logic             o_fval_fall,
  output logic             o_lval_fall,
  output logic             o_line_err,
  output logic [CNT_W-1:0] o_line_next,
  output logic [CNT_W-1:0] o_meas_width
);
  logic             r_fval_d;
  logic             r_lval_d;
  logic [CNT_W-1:0] r_pix_cnt;
  logic [CNT_W-1:0] r_line_cnt;
  logic [CNT_W:0]   w_pix_sum;
  logic [CNT_W-1:0] w_pix_inc;
  assign o_fval_rise = i_fval & ~r_fval_d;
  assign o_fval_fall = ~i_fval & r_fval_d;
  assign o_lval_fall = ~i_lval & r_lval_d;
  assign o_line_err  = i_line_en & o_lval_fall & (r_pix_cnt != i_width);
  // Line ending this cycle is already included, so a coincident frame end sees it.
  assign o_line_next = (i_line_en && o_lval_fall && ~&r_line_cnt) ? r_line_cnt + 1'b1 : r_line_cnt;
  assign w_pix_sum   = {1'b0, r_pix_cnt} + (CNT_W+1)'(2);
  assign w_pix_inc   = w_pix_sum[CNT_W] ? '1 : w_pix_sum[CNT_W-1:0];
  always_ff @(posedge rxclk_div or posedge sys_rst)
    if (sys_rst) begin
      r_fval_d   <= 1'b0;
      r_lval_d   <= 1'b0;
      r_pix_cnt  <= '0;
      r_line_cnt <= '0;
    end else begin
      r_fval_d   <= i_fval;
      r_lval_d   <= i_lval;
      r_line_cnt <= i_line_en ? o_line_next : '0;
      r_pix_cnt  <= (!i_pix_en || o_lval_fall) ? '0 : (i_fval & i_lval & i_dval) ? w_pix_inc : r_pix_cnt;
    end
`ifdef CL_FRAME_STATS_EN
  logic [CNT_W-1:0] r_meas_width;
  always_ff @(posedge rxclk_div or posedge sys_rst)
    if (sys_rst) r_meas_width <= '0;
    else if (i_pix_en && o_lval_fall) r_meas_width <= r_pix_cnt;
  assign o_meas_width = r_meas_width;
`else
  assign o_meas_width = '0;
`endif
endmodule

// File: rtl/cl_capture_ctrl.sv
// cl_capture_ctrl: Camera Link frame-acceptance sequencer, FIFO reset/write control, geometry errors.
// Optional per-frame geometry statistics are built when CL_FRAME_STATS_EN is defined.
module cl_capture_ctrl
  import cl_ctrl_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int SKIP_W = SKIP_W_DEF
) (
  input  logic                 rxclk_div,
  input  logic                 sys_rst,
  cl_capture_ctrl_if.slave     cam,
  input  logic                 locked,
  input  logic                 cfg_enable,
  input  logic                 dma_idle,
  input  logic                 dma_done,
  input  logic                 camera_sel,
  input  logic [CNT_W-1:0]     cfg_line_width,
  input  logic [CNT_W-1:0]     cfg_frame_height,
  input  logic [SKIP_W-1:0]    cfg_skip,
  input  logic                 err_clr,
  output logic                 frame_active,
  output logic                 frame_start,
  output logic                 frame_end,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic                 err_line_len,
  output logic                 err_height,
  output logic                 err_overflow,
  output logic [ST_W-1:0]      state_o,
  output logic [CNT_W-1:0]     meas_line_width,
  output logic [CNT_W-1:0]     meas_frame_height
);
  cl_state_e         r_state;
  logic [SKIP_W-1:0] r_skip_cnt;
  logic [CNT_W-1:0]  r_width;
  logic [CNT_W-1:0]  r_height;
  logic              w_run, w_elig, w_cap, w_pix_en, w_wr_try, w_line_err, w_h_err;
  logic              w_fval_rise, w_fval_fall, w_lval_fall, w_line_err_raw;
  logic [CNT_W-1:0]  w_line_next;
  assign w_run      = locked & cfg_enable;
  assign w_elig     = dma_idle & camera_sel;
  assign w_cap      = r_state == CAPTURE;
  assign w_wr_try   = w_run & w_cap & cam.fval & cam.lval & cam.dval;
  assign w_line_err = w_run & w_line_err_raw;
  assign w_h_err    = w_run & w_cap & w_fval_fall & (w_line_next != r_height);
  assign state_o    = r_state;
  cl_line_counter #(.CNT_W(CNT_W)) u_line (
    .rxclk_div   (rxclk_div),
    .sys_rst     (sys_rst),
    .i_fval      (cam.fval),
    .i_lval      (cam.lval),
    .i_dval      (cam.dval),
    .i_pix_en    (w_pix_en),
    .i_line_en   (w_cap),
    .i_width     (r_width),
    .o_fval_rise (w_fval_rise),
    .o_fval_fall (w_fval_fall),
    .o_lval_fall (w_lval_fall),
    .o_line_err  (w_line_err_raw),
    .o_line_next (w_line_next),
    .o_meas_width(meas_line_width)
  );
  always_ff @(posedge rxclk_div or posedge sys_rst)
    if (sys_rst) begin
      r_state          <= IDLE;
      cam.fifo_rst     <= 1'b1;
      cam.pixel_wr_en  <= 1'b0;
      frame_active     <= 1'b0;
      frame_start      <= 1'b0;
      frame_end        <= 1'b0;
      frame_cnt        <= '0;
      drop_cnt         <= '0;
      err_line_len     <= 1'b0;
      err_height       <= 1'b0;
      err_overflow     <= 1'b0;
      r_skip_cnt       <= '0;
      r_width          <= '0;
      r_height         <= '0;
    end else begin
      cam.pixel_wr_en <= w_wr_try & ~cam.fifo_full;
      frame_start     <= 1'b0;
      frame_end       <= 1'b0;
      err_line_len    <= (err_line_len & ~err_clr) | w_line_err;
      err_height      <= (err_height & ~err_clr) | w_h_err;
      err_overflow    <= (err_overflow & ~err_clr) | (w_wr_try & cam.fifo_full);
      if (!w_run) begin
        r_state      <= IDLE;
        cam.fifo_rst <= 1'b1;
        frame_active <= 1'b0;
      end else begin
        case (r_state)
          IDLE: r_state <= WAIT_FEND;
          WAIT_FEND: if (!cam.fval) begin
            r_state      <= ARMED;
            cam.fifo_rst <= 1'b0;
          end
          ARMED: if (w_fval_rise) begin
            if (w_elig && r_skip_cnt == '0) begin
              r_state      <= CAPTURE;
              frame_active <= 1'b1;
              frame_start  <= 1'b1;
              r_skip_cnt   <= cfg_skip;
              r_width      <= cfg_line_width;
              r_height     <= cfg_frame_height;
            end else begin
              r_state <= SKIP;
              if (w_elig) r_skip_cnt <= r_skip_cnt - 1'b1;
              else drop_cnt <= drop_cnt + CNT_W'(~&drop_cnt);
            end
          end
          SKIP: if (!cam.fval) r_state <= ARMED;
          CAPTURE: if (w_fval_fall) begin
            r_state   <= DRAIN;
            frame_end <= 1'b1;
            frame_cnt <= frame_cnt + 1'b1;
          end
          DRAIN: begin
            if (dma_done) begin
              r_state      <= WAIT_FEND;
              cam.fifo_rst <= 1'b1;
              frame_active <= 1'b0;
            end
            if (w_fval_rise) drop_cnt <= drop_cnt + CNT_W'(~&drop_cnt);
          end
          default: begin
            r_state      <= IDLE;
            cam.fifo_rst <= 1'b1;
            frame_active <= 1'b0;
          end
        endcase
      end
    end
`ifdef CL_FRAME_STATS_EN
  logic [CNT_W-1:0] r_skip_lines;
  logic [CNT_W-1:0] r_meas_h;
  logic [CNT_W-1:0] w_skip_next;
  // Skipped frames keep their own line count so capture geometry checks stay untouched.
  assign w_pix_en          = w_cap | (r_state == SKIP);
  assign w_skip_next       = (w_lval_fall && ~&r_skip_lines) ? r_skip_lines + 1'b1 : r_skip_lines;
  assign meas_frame_height = r_meas_h;
  always_ff @(posedge rxclk_div or posedge sys_rst)
    if (sys_rst) begin
      r_skip_lines <= '0;
      r_meas_h     <= '0;
    end else begin
      r_skip_lines <= (r_state == SKIP) ? w_skip_next : '0;
      if (w_fval_fall && w_cap) r_meas_h <= w_line_next;
      else if (w_fval_fall && r_state == SKIP) r_meas_h <= w_skip_next;
    end
`else
  logic w_unused;
  assign w_pix_en          = w_cap;
  assign meas_frame_height = '0;
  assign w_unused          = w_lval_fall;
`endif
endmodule

// File: tb/tb_cl_capture_ctrl.sv
// tb_cl_capture_ctrl: table-driven frame scenarios, hand corner sequences and a frame-level random model.
module tb_cl_capture_ctrl;
  import cl_ctrl_pkg::*;
  logic        rxclk_div = 1'b0;
  logic        sys_rst;
  logic        locked, cfg_enable, dma_idle, dma_done, camera_sel, err_clr;
  logic [15:0] cfg_line_width, cfg_frame_height;
  logic [3:0]  cfg_skip;
  logic        frame_active, frame_start, frame_end;
  logic [15:0] frame_cnt, drop_cnt, meas_line_width, meas_frame_height;
  logic        err_line_len, err_height, err_overflow;
  logic [2:0]  state_o;
  cl_capture_ctrl_if cam ();
  cl_capture_ctrl dut (
    .rxclk_div(rxclk_div), .sys_rst(sys_rst), .cam(cam), .locked(locked), .cfg_enable(cfg_enable),
    .dma_idle(dma_idle), .dma_done(dma_done), .camera_sel(camera_sel), .cfg_line_width(cfg_line_width),
    .cfg_frame_height(cfg_frame_height), .cfg_skip(cfg_skip), .err_clr(err_clr),
    .frame_active(frame_active), .frame_start(frame_start), .frame_end(frame_end),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .err_line_len(err_line_len), .err_height(err_height),
    .err_overflow(err_overflow), .state_o(state_o), .meas_line_width(meas_line_width),
    .meas_frame_height(meas_frame_height)
  );
  always #5 rxclk_div = ~rxclk_div;
  int n_wr = 0;
  always @(negedge rxclk_div) if (cam.pixel_wr_en === 1'b1) n_wr++;
  int n_chk = 0, n_pass = 0;
  int f_wr, f_lines;
  bit f_ovf, f_bad;
  int m_fc, m_dc, m_wr, m_skip;
  bit m_drain, m_el, m_eh, m_eo;
  typedef struct {
    logic [3:0] skip;
    bit idle, sel, done;
    int fc, dc, wr, st;
  } row_t;
  row_t rows[12];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else n_pass++;
  endtask
  task automatic step();
    @(posedge rxclk_div);
    #1;
  endtask
  task automatic settle();
    repeat (3) step();
  endtask
  task automatic pulse_done();
    dma_done = 1'b1; step(); dma_done = 1'b0;
  endtask
  task automatic frame(input int nl, input int dv, input int bad, input int bad_dv, input bit joint,
                       input int full_pct, input bit gaps);
    f_wr = 0; f_ovf = 0; f_bad = 0; f_lines = nl;
    cam.fval = 1'b1; step();
    for (int l = 0; l < nl; l++) begin
      int n;
      n = (l == bad) ? bad_dv : dv;
      if (2 * n != int'(cfg_line_width)) f_bad = 1;
      for (int p = 0; p < n; p++) begin
        if (gaps && $urandom_range(0, 3) == 0) begin
          cam.lval = 1'b1; cam.dval = 1'b0; cam.fifo_full = 1'b0; step();
        end
        cam.lval = 1'b1; cam.dval = 1'b1;
        cam.fifo_full = ($urandom_range(0, 99) < full_pct);
        if (cam.fifo_full) f_ovf = 1; else f_wr++;
        step();
      end
      cam.lval = 1'b0; cam.dval = 1'b0; cam.fifo_full = 1'b0;
      if (joint && l == nl - 1) cam.fval = 1'b0;
      step();
    end
    cam.fval = 1'b0; step();
  endtask
  task automatic model_frame(input bit idle, input bit sel);
    if (m_drain) m_dc++;
    else if (idle && sel) begin
      if (m_skip == 0) begin
        m_skip = int'(cfg_skip); m_fc++; m_wr += f_wr; m_drain = 1;
        m_el |= f_bad; m_eh |= (f_lines != int'(cfg_frame_height)); m_eo |= f_ovf;
      end else m_skip--;
    end else m_dc++;
  endtask
  initial begin
    int base, w0;
    sys_rst = 1'b1; locked = 1'b0; cfg_enable = 1'b0; dma_idle = 1'b1; dma_done = 1'b0; camera_sel = 1'b1;
    err_clr = 1'b0; cfg_line_width = 16'd8; cfg_frame_height = 16'd4; cfg_skip = 4'd0;
    cam.fval = 1'b0; cam.lval = 1'b0; cam.dval = 1'b0; cam.fifo_full = 1'b0;
    rows[0]  = '{4'd0, 1, 1, 1, 1, 0, 16, 2};
    rows[1]  = '{4'd2, 1, 1, 1, 2, 0, 32, 2};
    rows[2]  = '{4'd2, 1, 1, 1, 2, 0, 32, 2};
    rows[3]  = '{4'd2, 1, 1, 1, 2, 0, 32, 2};
    rows[4]  = '{4'd2, 1, 1, 1, 3, 0, 48, 2};
    rows[5]  = '{4'd2, 1, 1, 1, 3, 0, 48, 2};
    rows[6]  = '{4'd2, 1, 1, 1, 3, 0, 48, 2};
    rows[7]  = '{4'd0, 0, 1, 1, 3, 1, 48, 2};
    rows[8]  = '{4'd0, 1, 1, 0, 4, 1, 64, 5};
    rows[9]  = '{4'd0, 1, 1, 1, 4, 2, 64, 2};
    rows[10] = '{4'd0, 1, 0, 1, 4, 3, 64, 2};
    rows[11] = '{4'd0, 1, 1, 1, 5, 3, 80, 2};
    step(); step();
    chk("rst_state", state_o, 0);
    chk("rst_fifo_rst", cam.fifo_rst, 1);
    chk("rst_wr_en", cam.pixel_wr_en, 0);
    chk("rst_outputs", {frame_active, frame_start, frame_end, err_line_len, err_height, err_overflow}, 0);
    chk("rst_counts", {frame_cnt, drop_cnt}, 0);
    sys_rst = 1'b0; locked = 1'b1; cfg_enable = 1'b1;
    step();
    chk("wait_fend_state", state_o, 1);
    chk("wait_fend_fifo_rst", cam.fifo_rst, 1);
    step();
    chk("armed_state", state_o, 2);
    chk("armed_fifo_rst", cam.fifo_rst, 0);
    base = n_wr;
    for (int i = 0; i < 12; i++) begin
      cfg_skip = rows[i].skip; dma_idle = rows[i].idle; camera_sel = rows[i].sel;
      frame(4, 4, -1, 0, 0, 0, 0);
      step(); step();
      if (rows[i].done) pulse_done();
      settle();
      chk($sformatf("row%0d_frame_cnt", i), frame_cnt, rows[i].fc);
      chk($sformatf("row%0d_drop_cnt", i), drop_cnt, rows[i].dc);
      chk($sformatf("row%0d_writes", i), n_wr - base, rows[i].wr);
      chk($sformatf("row%0d_state", i), state_o, rows[i].st);
      chk($sformatf("row%0d_errors", i), {err_line_len, err_height, err_overflow}, 0);
    end
    dma_idle = 1'b1; camera_sel = 1'b1; cfg_skip = 4'd0;
    cfg_enable = 1'b0; step();
    chk("disable_state", state_o, 0);
    chk("disable_fifo_rst", cam.fifo_rst, 1);
    cam.fval = 1'b1; step();
    cfg_enable = 1'b1; step();
    w0 = n_wr;
    cam.lval = 1'b1; cam.dval = 1'b1; repeat (4) step();
    cam.lval = 1'b0; cam.dval = 1'b0; step();
    chk("midframe_state", state_o, 1);
    chk("midframe_fifo_rst", cam.fifo_rst, 1);
    chk("midframe_no_writes", n_wr - w0, 0);
    cam.fval = 1'b0; step(); step();
    chk("midframe_armed", state_o, 2);
    w0 = n_wr;
    frame(4, 4, -1, 0, 0, 0, 0); step(); step();
    chk("next_frame_cnt", frame_cnt, 6);
    chk("next_frame_writes", n_wr - w0, 16);
    pulse_done(); settle();
    frame(4, 4, -1, 0, 1, 0, 0); step(); step();
    chk("joint_end_frame_cnt", frame_cnt, 7);
    chk("joint_end_no_errors", {err_line_len, err_height}, 0);
    pulse_done(); settle();
    frame(3, 4, 1, 3, 0, 0, 0); step(); step();
    chk("short_line_err", err_line_len, 1);
    chk("short_frame_err", err_height, 1);
    chk("geom_err_no_ovf", err_overflow, 0);
    pulse_done(); settle();
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("err_clr_clears", {err_line_len, err_height}, 0);
    cam.fval = 1'b1; step();
    chk("frame_start_pulse", frame_start, 1);
    chk("capture_state", state_o, 3);
    chk("frame_active_high", frame_active, 1);
    for (int l = 0; l < 3; l++) begin
      cam.lval = 1'b1; cam.dval = 1'b1; repeat (4) step();
      cam.lval = 1'b0; cam.dval = 1'b0; step();
    end
    cam.fval = 1'b0; err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("set_beats_clr", err_height, 1);
    chk("clr_line_len", err_line_len, 0);
    chk("frame_end_pulse", frame_end, 1);
    chk("drain_state", state_o, 5);
    step();
    chk("frame_end_one_cycle", frame_end, 0);
    pulse_done(); settle();
    err_clr = 1'b1; step(); err_clr = 1'b0;
    cam.fval = 1'b1; step();
    cam.lval = 1'b1; cam.dval = 1'b1; step();
    chk("write_before_abort", cam.pixel_wr_en, 1);
    locked = 1'b0; step();
    chk("abort_state", state_o, 0);
    chk("abort_fifo_rst", cam.fifo_rst, 1);
    chk("abort_wr_en", cam.pixel_wr_en, 0);
    chk("abort_no_frame_end", {frame_end, frame_active}, 0);
    chk("abort_frame_cnt", frame_cnt, 9);
    cam.fval = 1'b0; cam.lval = 1'b0; cam.dval = 1'b0; locked = 1'b1; settle();
    chk("abort_no_err", {err_line_len, err_height, err_overflow}, 0);
    chk("relock_armed", state_o, 2);
    cam.fval = 1'b1; step();
    cam.lval = 1'b1; cam.dval = 1'b1; cam.fifo_full = 1'b1; step();
    chk("full_write_suppressed", cam.pixel_wr_en, 0);
    chk("overflow_set", err_overflow, 1);
    cam.fifo_full = 1'b0; step();
    chk("write_after_full", cam.pixel_wr_en, 1);
    cam.lval = 1'b0; cam.dval = 1'b0; step();
    cam.fval = 1'b0; step(); step();
    chk("ovf_frame_cnt", frame_cnt, 10);
    pulse_done(); settle();
    sys_rst = 1'b1; step(); sys_rst = 1'b0; settle();
    base = n_wr;
    m_fc = 0; m_dc = 0; m_wr = 0; m_skip = 0; m_drain = 0; m_el = 0; m_eh = 0; m_eo = 0;
    for (int i = 0; i < 40; i++) begin
      bit idle, sel;
      int nl, dv, bad;
      cfg_skip = 4'($urandom_range(0, 2));
      cfg_line_width = 16'(2 * $urandom_range(2, 4));
      cfg_frame_height = 16'($urandom_range(2, 4));
      idle = ($urandom_range(0, 3) != 0); sel = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        err_clr = 1'b1; step(); err_clr = 1'b0;
        m_el = 0; m_eh = 0; m_eo = 0;
      end
      dma_idle = idle; camera_sel = sel;
      nl = $urandom_range(2, 4); dv = $urandom_range(2, 4);
      bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
      frame(nl, dv, bad, dv + 1, 1'($urandom_range(0, 1)), 15, 1);
      model_frame(idle, sel);
      step(); step();
      if ($urandom_range(0, 3) != 0) begin
        pulse_done(); m_drain = 0;
      end
      settle();
      chk($sformatf("rnd%0d_frame_cnt", i), frame_cnt, m_fc);
      chk($sformatf("rnd%0d_drop_cnt", i), drop_cnt, m_dc);
      chk($sformatf("rnd%0d_writes", i), n_wr - base, m_wr);
      chk($sformatf("rnd%0d_err_line_len", i), err_line_len, m_el);
      chk($sformatf("rnd%0d_err_height", i), err_height, m_eh);
      chk($sformatf("rnd%0d_err_overflow", i), err_overflow, m_eo);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
